// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit with in-order response FIFO and redirect drain
//
// Issues sequential word fetches to an in-order instruction memory and hands
// the returned words to decode together with their addresses. A control
// transfer from the next-PC stage restarts fetch at the new target. Responses
// already in flight at that point are counted and discarded as they arrive.
//
// Parameters
//   XLEN        address / instruction width
//   RESET_PC    first fetch address after reset
//
// Ports
//   clk             clock, all state changes on its rising edge
//   reset           asynchronous active-high reset
//   redirect_valid  control transfer this cycle
//   redirect_pc     control transfer target (low two bits ignored)
//   imem_req        memory request valid
//   imem_addr       memory request address, word aligned
//   imem_gnt        memory accepts the request
//   imem_rvalid     memory response valid, in request order
//   imem_rdata      memory response word
//   inst_valid      instruction available to decode
//   inst_ready      decode accepts the instruction
//   inst_out        instruction word
//   inst_pc         address of inst_out
module ifetch_unit #(
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_out,
   output logic [XLEN-1:0] inst_pc
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]      out_q, out_d;
   logic [1:0]      drop_q, drop_d;
   logic [1:0]      occ_q, occ_d;

   // Entry 0 is always the oldest; both queues shift toward 0 on pop.
   logic [XLEN-1:0] fifo_pc_q  [2];
   logic [XLEN-1:0] fifo_pc_d  [2];
   logic [XLEN-1:0] fifo_ins_q [2];
   logic [XLEN-1:0] fifo_ins_d [2];
   logic [XLEN-1:0] tag_q      [2];
   logic [XLEN-1:0] tag_d      [2];

   logic            gnt_fire;
   logic            rsp_fire;
   logic            pop;
   logic            push;
   logic [1:0]      out_next;
   logic            tag_wr_idx;
   logic            fifo_wr_idx;
   logic [XLEN-1:0] redirect_aligned;
   logic            unused_redirect_bits;

   assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_bits = ^redirect_pc[1:0];

   // Credit check: every outstanding request has a FIFO slot reserved for it,
   // so the FIFO can never overflow and the memory never has to be stalled.
   assign imem_req   = (state_q == ST_RUN) && (({1'b0, out_q} + {1'b0, occ_q}) < 3'd2);
   assign imem_addr  = fetch_pc_q;

   assign inst_valid = (occ_q != 2'd0);
   assign inst_out   = inst_valid ? fifo_ins_q[0] : '0;
   assign inst_pc    = inst_valid ? fifo_pc_q[0]  : '0;

   assign gnt_fire   = imem_req && imem_gnt;
   // A response with nothing outstanding is spurious and ignored entirely.
   assign rsp_fire   = imem_rvalid && (out_q != 2'd0);
   assign pop        = inst_valid && inst_ready;
   // A redirect in the same cycle makes the arriving word stale.
   assign push       = rsp_fire && (state_q == ST_RUN) && !redirect_valid;

   assign out_next   = out_q + {1'b0, gnt_fire} - {1'b0, rsp_fire};

   // A grant only happens with at most one request outstanding, so the new
   // tag lands in slot 1 only when one older tag stays behind.
   assign tag_wr_idx  = (out_q == 2'd1) && !rsp_fire;
   // A push implies at least one outstanding, so occupancy is at most one.
   assign fifo_wr_idx = (occ_q == 2'd1) && !pop;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      out_d      = out_next;
      drop_d     = drop_q;
      occ_d      = occ_q - {1'b0, pop} + {1'b0, push};
      fifo_pc_d  = fifo_pc_q;
      fifo_ins_d = fifo_ins_q;
      tag_d      = tag_q;

      // Tag queue tracks every in-flight request, including ones being dropped.
      if (rsp_fire) begin
         tag_d[0] = tag_q[1];
      end
      if (gnt_fire) begin
         tag_d[tag_wr_idx] = fetch_pc_q;
      end

      if (pop) begin
         fifo_pc_d[0]  = fifo_pc_q[1];
         fifo_ins_d[0] = fifo_ins_q[1];
      end
      if (push) begin
         fifo_pc_d[fifo_wr_idx]  = tag_q[0];
         fifo_ins_d[fifo_wr_idx] = imem_rdata;
      end

      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            if (redirect_valid) begin
               fetch_pc_d = redirect_aligned;
            end
         end
         ST_RUN: begin
            if (gnt_fire) begin
               fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (redirect_valid) begin
               // Whatever is still in flight after this edge belongs to the
               // old path; the head popped this cycle has been delivered.
               fetch_pc_d = redirect_aligned;
               occ_d      = 2'd0;
               drop_d     = out_next;
               state_d    = (out_next != 2'd0) ? ST_DRAIN : ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (rsp_fire) begin
               drop_d = drop_q - 2'd1;
               if (drop_q == 2'd1) begin
                  state_d = ST_RUN;
               end
            end
            // Drop count already covers everything in flight; only the
            // restart address changes.
            if (redirect_valid) begin
               fetch_pc_d = redirect_aligned;
               occ_d      = 2'd0;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         fetch_pc_q    <= RESET_PC;
         out_q         <= 2'd0;
         drop_q        <= 2'd0;
         occ_q         <= 2'd0;
         fifo_pc_q[0]  <= '0;
         fifo_pc_q[1]  <= '0;
         fifo_ins_q[0] <= '0;
         fifo_ins_q[1] <= '0;
         tag_q[0]      <= '0;
         tag_q[1]      <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         out_q         <= out_d;
         drop_q        <= drop_d;
         occ_q         <= occ_d;
         fifo_pc_q     <= fifo_pc_d;
         fifo_ins_q    <= fifo_ins_d;
         tag_q         <= tag_d;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

   localparam logic [31:0] K = 32'hC0DE_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;

   logic        w_reset;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ivalid;
   logic [31:0] w_iout;
   logic [31:0] w_ipc;

   int          n_cmp = 0;
   int          n_err = 0;
   int          grants;
   logic [31:0] mem_q [$];
   logic [31:0] got_pc [$];
   logic [31:0] got_ins [$];
   bit          mem_hold;
   bit          spurious;
   bit          mem_rv_real;

   ifetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_out(inst_out), .inst_pc(inst_pc)
   );

   ifetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .reset(w_reset),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
      .imem_rvalid(1'b0), .imem_rdata(32'h0),
      .inst_valid(w_ivalid), .inst_ready(1'b0),
      .inst_out(w_iout), .inst_pc(w_ipc)
   );

   always #5 clk = ~clk;

   task automatic mem_drive();
      mem_rv_real = (mem_q.size() > 0) && !mem_hold;
      imem_rvalid = mem_rv_real || spurious;
      imem_rdata  = mem_rv_real ? (mem_q[0] ^ K) : 32'h0;
   endtask

   task automatic cycle();
      logic        fired;
      logic [31:0] faddr;
      logic        drove;
      fired = imem_req && imem_gnt;
      faddr = imem_addr;
      drove = mem_rv_real;
      if (inst_valid && inst_ready) begin
         got_pc.push_back(inst_pc);
         got_ins.push_back(inst_out);
      end
      if (fired) grants++;
      @(posedge clk);
      #1;
      if (drove) void'(mem_q.pop_front());
      if (fired) mem_q.push_back(faddr);
      mem_drive();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      inst_ready = 1'b0;
      imem_gnt = 1'b1;
      mem_hold = 1'b0;
      spurious = 1'b0;
      mem_q.delete();
      got_pc.delete();
      got_ins.delete();
      grants = 0;
      mem_drive();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
      n_cmp++; if (inst_out !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h want 0", inst_out); end
      n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      n_cmp++; if (w_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL reset_waddr: got %h want fffffff8", w_addr); end
   endtask

   task automatic test_boot();
      do_reset();
      inst_ready = 1'b1;
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_noreq: got %b want 0", imem_req); end
      cycle();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL boot_addr0: got req %b addr %h want 1 0", imem_req, imem_addr); end
      cycle();
      n_cmp++; if (imem_addr !== 32'h4) begin n_err++; $display("FAIL boot_addr4: got %h want 4", imem_addr); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL boot_early_valid: got %b want 0", inst_valid); end
      cycle();
      n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL boot_addr8: got %h want 8", imem_addr); end
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_err++; $display("FAIL boot_first: got valid %b pc %h want 1 0", inst_valid, inst_pc); end
      n_cmp++; if (inst_out !== K) begin n_err++; $display("FAIL boot_word: got %h want %h", inst_out, K); end
   endtask

   task automatic test_stream();
      do_reset();
      inst_ready = 1'b1;
      for (int i = 0; i < 30; i++) cycle();
      n_cmp++; if (got_pc.size() < 8) begin n_err++; $display("FAIL stream_count: got %0d want >=8", got_pc.size()); end
      for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
         n_cmp++;
         if (got_pc[i] !== 32'(4 * i) || got_ins[i] !== (32'(4 * i) ^ K)) begin
            n_err++; $display("FAIL stream_%0d: got pc %h word %h want pc %h", i, got_pc[i], got_ins[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      int viol;
      viol = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (grants - got_pc.size() > 2) viol++;
      end
      n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL bp_credit: got %0d violations want 0", viol); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req: got %b want 0", imem_req); end
      n_cmp++; if (grants !== 2) begin n_err++; $display("FAIL bp_grants: got %0d want 2", grants); end
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_err++; $display("FAIL bp_head: got valid %b pc %h want 1 0", inst_valid, inst_pc); end
      inst_ready = 1'b1;
      for (int i = 0; i < 60 && got_pc.size() < 6; i++) cycle();
      n_cmp++; if (got_pc.size() < 6) begin n_err++; $display("FAIL bp_count: got %0d want >=6", got_pc.size()); end
      for (int i = 0; i < 6 && i < got_pc.size(); i++) begin
         n_cmp++;
         if (got_pc[i] !== 32'(4 * i)) begin n_err++; $display("FAIL bp_order_%0d: got %h want %h", i, got_pc[i], 32'(4 * i)); end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      inst_ready = 1'b1;
      mem_hold = 1'b1;
      mem_drive();
      cycle(); cycle(); cycle();
      n_cmp++; if (grants !== 2 || imem_req !== 1'b0) begin n_err++; $display("FAIL rd_setup: got grants %0d req %b want 2 0", grants, imem_req); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      cycle();
      redirect_valid = 1'b0;
      n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin n_err++; $display("FAIL rd_drain: got req %b addr %h want 0 100", imem_req, imem_addr); end
      mem_hold = 1'b0;
      mem_drive();
      cycle();
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rd_still_drain: got %b want 0", imem_req); end
      cycle();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL rd_resume: got req %b addr %h want 1 100", imem_req, imem_addr); end
      for (int i = 0; i < 40 && got_pc.size() < 2; i++) cycle();
      n_cmp++; if (got_pc.size() < 2) begin n_err++; $display("FAIL rd_timeout: got %0d words want 2", got_pc.size()); end
      n_cmp++; if (got_pc[0] !== 32'h100 || got_ins[0] !== (32'h100 ^ K)) begin n_err++; $display("FAIL rd_first: got pc %h word %h want 100", got_pc[0], got_ins[0]); end
      n_cmp++; if (got_pc[1] !== 32'h104) begin n_err++; $display("FAIL rd_second: got %h want 104", got_pc[1]); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      inst_ready = 1'b1;
      cycle(); cycle();
      n_cmp++; if (imem_req !== 1'b1 || imem_rvalid !== 1'b1) begin n_err++; $display("FAIL sim_setup: got req %b rvalid %b want 1 1", imem_req, imem_rvalid); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      cycle();
      redirect_valid = 1'b0;
      n_cmp++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin n_err++; $display("FAIL sim_drain: got req %b valid %b want 0 0", imem_req, inst_valid); end
      mem_hold = 1'b1;
      mem_drive();
      cycle(); cycle();
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL sim_wait: got %b want 0", imem_req); end
      mem_hold = 1'b0;
      mem_drive();
      cycle();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL sim_resume: got req %b addr %h want 1 200", imem_req, imem_addr); end
      for (int i = 0; i < 40 && got_pc.size() < 1; i++) cycle();
      n_cmp++; if (got_pc.size() < 1 || got_pc[0] !== 32'h200) begin n_err++; $display("FAIL sim_first: got n %0d pc %h want 200", got_pc.size(), got_pc[0]); end
   endtask

   task automatic test_redirect_pop();
      do_reset();
      inst_ready = 1'b1;
      cycle(); cycle(); cycle();
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_err++; $display("FAIL rp_setup: got valid %b pc %h want 1 0", inst_valid, inst_pc); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0300;
      cycle();
      redirect_valid = 1'b0;
      n_cmp++; if (got_pc.size() !== 1 || got_pc[0] !== 32'h0) begin n_err++; $display("FAIL rp_delivered: got n %0d pc %h want 1 0", got_pc.size(), got_pc[0]); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rp_flush: got %b want 0", inst_valid); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_err++; $display("FAIL rp_run: got req %b addr %h want 1 300", imem_req, imem_addr); end
      for (int i = 0; i < 40 && got_pc.size() < 2; i++) cycle();
      n_cmp++; if (got_pc.size() < 2 || got_pc[1] !== 32'h300) begin n_err++; $display("FAIL rp_next: got n %0d pc %h want 300", got_pc.size(), got_pc[1]); end
   endtask

   task automatic test_spurious();
      do_reset();
      inst_ready = 1'b1;
      imem_gnt = 1'b0;
      cycle();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL sp_req: got req %b addr %h want 1 0", imem_req, imem_addr); end
      spurious = 1'b1;
      mem_drive();
      cycle();
      spurious = 1'b0;
      mem_drive();
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL sp_ignored: got %b want 0", inst_valid); end
      cycle();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL sp_hold: got req %b addr %h want 1 0", imem_req, imem_addr); end
      imem_gnt = 1'b1;
      for (int i = 0; i < 40 && got_pc.size() < 2; i++) cycle();
      n_cmp++; if (got_pc.size() < 2 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin n_err++; $display("FAIL sp_stream: got n %0d pc %h %h want 0 4", got_pc.size(), got_pc[0], got_pc[1]); end
   endtask

   task automatic test_wrap();
      @(posedge clk);
      #1;
      w_reset = 1'b0;
      n_cmp++; if (w_req !== 1'b0 || w_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_boot: got req %b addr %h want 0 fffffff8", w_req, w_addr); end
      @(posedge clk); #1;
      n_cmp++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL wrap_a0: got req %b addr %h want 1 fffffff8", w_req, w_addr); end
      @(posedge clk); #1;
      n_cmp++; if (w_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_a1: got %h want fffffffc", w_addr); end
      @(posedge clk); #1;
      n_cmp++; if (w_addr !== 32'h0 || w_req !== 1'b0) begin n_err++; $display("FAIL wrap_a2: got addr %h req %b want 0 0", w_addr, w_req); end
      n_cmp++; if (w_ivalid !== 1'b0) begin n_err++; $display("FAIL wrap_valid: got %b want 0", w_ivalid); end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      inst_ready = 1'b1;
      mem_hold = 1'b1;
      mem_drive();
      cycle(); cycle(); cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0040;
      cycle();
      redirect_valid = 1'b0;
      n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h40) begin n_err++; $display("FAIL md_setup: got req %b addr %h want 0 40", imem_req, imem_addr); end
      reset = 1'b1;
      w_reset = 1'b1;
      #1;
      n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL md_req_addr: got req %b addr %h want 0 0", imem_req, imem_addr); end
      n_cmp++; if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0) begin n_err++; $display("FAIL md_inst: got %b %h %h want 0 0 0", inst_valid, inst_out, inst_pc); end
      n_cmp++; if (w_req !== 1'b0 || w_addr !== 32'hFFFF_FFF8 || w_iout !== 32'h0 || w_ipc !== 32'h0) begin n_err++; $display("FAIL md_wrap: got req %b addr %h want 0 fffffff8", w_req, w_addr); end
      do_reset();
      inst_ready = 1'b1;
      for (int i = 0; i < 40 && got_pc.size() < 1; i++) cycle();
      n_cmp++; if (got_pc.size() < 1 || got_pc[0] !== 32'h0 || got_ins[0] !== K) begin n_err++; $display("FAIL md_restart: got n %0d pc %h word %h want 0 %h", got_pc.size(), got_pc[0], got_ins[0], K); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      w_reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      inst_ready = 1'b0;
      imem_gnt = 1'b1;
      mem_hold = 1'b0;
      spurious = 1'b0;
      grants = 0;
      mem_drive();
      #2;
      test_reset();
      test_boot();
      test_stream();
      test_backpressure();
      test_redirect();
      test_simultaneous();
      test_redirect_pop();
      test_spurious();
      test_wrap();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the address and instruction width.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 redirect_valid  input  1  control transfer (taken branch, jal or jalr) reported by the next-PC stage this cycle.
REQ-006 redirect_pc  input  XLEN  target address, valid when redirect_valid is high.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  XLEN  request address; bits [1:0] always 0.
REQ-009 imem_gnt  input  1  memory accepts the request this cycle.
REQ-010 imem_rvalid  input  1  response data valid; responses return in order, at least 1 cycle after grant.
REQ-011 imem_rdata  input  XLEN  response instruction word.
REQ-012 inst_valid  output  1  instruction available to decode.
REQ-013 inst_ready  input  1  decode accepts the instruction.
REQ-014 inst_out  output  XLEN  instruction word.
REQ-015 inst_pc  output  XLEN  address of inst_out, consumed by the next-PC stage as currentpc.

Function
REQ-016 The block SHALL keep fetch_pc, a 2-entry in-order FIFO of {pc, instr}, an outstanding counter (0..2) and a drop counter (0..2).
REQ-017 The block SHALL implement FSM states BOOT, RUN and DRAIN; reset enters BOOT, and BOOT moves to RUN unconditionally on the next edge with no request issued in BOOT.
REQ-018 In RUN, imem_req SHALL be high iff outstanding + FIFO occupancy < 2, with imem_addr = fetch_pc.
REQ-019 On imem_req && imem_gnt, the block SHALL increment outstanding, push fetch_pc into a pc-tag queue and set fetch_pc to fetch_pc + 4, taken modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
REQ-020 On imem_rvalid with drop = 0, the block SHALL pop the tag, write {tag, imem_rdata} into the FIFO and decrement outstanding; the word SHALL appear on inst_valid the following cycle (1-cycle latency) and never combinationally.
REQ-021 inst_valid SHALL equal FIFO non-empty, with inst_out and inst_pc taken from the FIFO head, and the head SHALL pop on inst_valid && inst_ready.
REQ-022 Simultaneous FIFO push and pop SHALL be legal, and occupancy SHALL never exceed 2, guaranteed by REQ-018.
REQ-023 On redirect_valid, the block SHALL perform the following:
- set fetch_pc to {redirect_pc[XLEN-1:2], 2'b00};
- flush all FIFO entries not popped this same cycle;
- set drop to outstanding, counting a grant in the same cycle and subtracting a response in the same cycle;
- go to DRAIN if drop ≠ 0, else stay in RUN.
REQ-024 Redirect SHALL take priority over a same-cycle push, and a head popped in the same cycle as a redirect SHALL count as delivered.
REQ-025 In DRAIN, imem_req SHALL be 0; each imem_rvalid SHALL be discarded and decrement both drop and outstanding, and the block SHALL return to RUN on the edge where drop reaches 0.
REQ-026 A redirect during DRAIN SHALL overwrite fetch_pc, and drop SHALL be left unchanged.
REQ-027 imem_rvalid with outstanding = 0 SHALL be ignored.
REQ-028 imem_addr SHALL be held stable while imem_req is high and imem_gnt is low.

Reset
REQ-029 Asserting reset at any time SHALL asynchronously clear FIFO, outstanding, drop and tag queue, set fetch_pc to RESET_PC and set the FSM to BOOT.
REQ-030 During reset, imem_req = 0, inst_valid = 0, inst_out = 0, inst_pc = 0 and imem_addr = RESET_PC.
REQ-031 A reset in mid-transaction SHALL abandon in-flight responses, and the memory model SHALL be reset together with the block.

Verification
REQ-032 Boot: release reset, with gnt always 1 and rvalid 1 cycle later -> imem_addr = 0, 4, 8 on successive cycles; inst_pc = 0 appears 3 cycles after reset release.
REQ-033 Backpressure: inst_ready = 0 for 10 cycles -> occupancy + outstanding stays ≤ 2, imem_req drops, no word is lost or duplicated, and inst_pc stays in order after release.
REQ-034 Redirect with 2 outstanding: redirect_pc = 32'h0000_0103 -> next request address is 32'h0000_0100, the 2 stale responses are dropped, and the first inst_pc after the redirect is 32'h0000_0100.
REQ-035 Simultaneous events: redirect, grant and rvalid in the same cycle -> drop = 1, and the FSM returns to RUN after exactly one further response.
REQ-036 Wrap and reset: RESET_PC = 32'hFFFF_FFF8 -> addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000; asserting reset mid-drain returns all outputs to REQ-030 values immediately.
